data_ram_master: RTL and testbench
==================================

# data_ram_master

Processor-side initiator for the data RAM port. Accepts one load, store or clear request at a time from the control unit and drives the RAM's write/read/clear strobes, address and data lines. On a read it waits for the RAM's `dataReady`, captures `readData`, and returns a single-cycle response. Sits between the processor control FSM and the data RAM.

## Interface
- `width`, 8, data word width; must match the RAM.
- `length`, 8, address width; the RAM holds 2**length words.
- `timeout`, 15, maximum cycles spent in READ before an error response; only used with `DATA_RAM_TIMEOUT_EN`.
- `clk`  in  1  single clock. All logic is on the rising edge; the RAM samples on the falling edge.
- `clr`  in  1  reset, synchronous, active-high.
- `reqValid`  in  1  a request is present.
- `reqOp`  in  2  01 = read, 10 = write, 11 = clear RAM, 00 = no-op (never accepted).
- `reqAddr`  in  length  word address.
- `reqData`  in  width  store data.
- `reqReady`  out  1  block can accept a request.
- `respValid`  out  1  one-cycle completion pulse.
- `respErr`  out  1  qualifies `respValid`; the read timed out.
- `respData`  out  width  last read data; held between reads.
- `ramWriteEnable`, `ramReadEnable`  out  1 each  RAM strobes.
- `ramClrN`  out  1  RAM clear, active-low.
- `ramAddr`, `ramReadAddr`  out  length each  RAM write and read addresses.
- `ramWriteData`  out  width  RAM write data.
- `ramDataReady`  in  1  RAM read-complete flag.
- `ramReadData`  in  width  RAM read data.

## Operation
- **States:** IDLE, WRITE, READ, CLEAR.
- **`reqReady`** = (state == IDLE) && !clr. Handshake occurs when `reqValid && reqReady` with a nonzero op.
- **Request capture:** on handshake, latch `reqAddr` onto `ramAddr`/`ramReadAddr` and `reqData` onto `ramWriteData`. Then go to:
  - WRITE, asserting `ramWriteEnable`;
  - READ, asserting `ramReadEnable`;
  - CLEAR, driving `ramClrN` = 0.
- **WRITE / CLEAR:** on the next edge, drop the strobe, pulse `respValid` (`respErr` = 0), return to IDLE.
- **READ:** at each edge, sample `ramDataReady`.
  - If 1: `respData` <= `ramReadData`, drop `ramReadEnable`, pulse `respValid`, return to IDLE.
  - If 0: stay in READ.
- At most one strobe is ever active; strobe outputs are registered.
- `respData` changes only on a successful read.
- Request inputs are ignored outside IDLE. Op 00 is never accepted.
- **Reset values:** state IDLE, all strobes 0, `ramClrN` = 1, `respValid` = `respErr` = 0, `respData` = 0, addresses and write data = 0.
- **Reset mid-operation:** all strobes are forced inactive at that edge and no response is issued.

## Timing
- Request accepted at edge E0; the strobe is high from E0 to E1, spanning exactly one RAM falling edge.
- **Write / clear:** `respValid` is high from E1 to E2. Next accept is possible at E2, giving one request per 2 cycles.
- **Read, nominal:** RAM asserts `dataReady` at the falling edge between E0 and E1. Capture at E1; `respValid` from E1 to E2.
  - Clock period must exceed 20 ns, since RAM read data settles 10 ns after the falling edge.
- **Stale `ramDataReady`:** it clears at the RAM falling edge after the read strobe drops, which is before any new READ can sample it. No extra guard is required.
- **Wait cycles:** a read with k extra wait cycles responds at E(1+k).

## Configuration
- **`DATA_RAM_TIMEOUT_EN` defined:**
  - A cycle counter clears on READ entry and increments every READ cycle.
  - When it reaches `timeout` with `ramDataReady` still 0: drop `ramReadEnable`, pulse `respValid` with `respErr` = 1, keep `respData` unchanged, return to IDLE.
  - A `ramDataReady` sampled on the same edge as the timeout wins (normal completion).
- **Not defined:** READ waits indefinitely, `respErr` is tied 0, and no counter is present.

## Structure
- Shared package `data_ram_pkg` holds the op codes (OP_NOP, OP_READ, OP_WRITE, OP_CLEAR) and the state encodings.
- One sub-module, `data_ram_timeout_ctr`: a clear/enable counter with an expiry flag, instantiated only under `DATA_RAM_TIMEOUT_EN`.

## Test plan
- **Write:** write op, addr 0x05, data 0xA3 -> `ramWriteEnable` high for exactly one cycle with `ramAddr` = 0x05; `respValid` the next cycle; RAM model word 5 = 0xA3.
- **Read-back:** read op, addr 0x05 -> `ramReadEnable` high one cycle; `respData` = 0xA3 with `respValid` at E1.
- **Clear:** clear op -> `ramClrN` low one cycle; a following read of addr 0x05 returns 0x00.
- **Delayed ready:** RAM model holds `dataReady` low for 3 cycles -> `respValid` at E4, `reqReady` low throughout.
- **Reset mid-read:** assert `clr` during READ -> all strobes 0 at that edge, no `respValid`, `reqReady` returns after `clr` deasserts.
- **Timeout (`DATA_RAM_TIMEOUT_EN`, `timeout` = 15):** `dataReady` stuck low -> `respValid` with `respErr` = 1 after 15 READ cycles; `respData` unchanged.

Source files
------------

// File: rtl/data_ram_master_pkg.sv
// Shared op codes and FSM state encodings for the data RAM initiator and its helpers.
package data_ram_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10,
    ST_CLEAR = 2'b11
  } state_e;

endpackage

// File: rtl/data_ram_master_if.sv
// Request/response handshake plus RAM strobe/address/data lines for the data RAM initiator.
// The master modport is the initiator's view; the slave modport is the environment (control unit + RAM).
interface data_ram_master_if #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 8
);
  logic              reqValid;
  logic [1:0]        reqOp;
  logic [LENGTH-1:0] reqAddr;
  logic [WIDTH-1:0]  reqData;
  logic              reqReady;
  logic              respValid;
  logic              respErr;
  logic [WIDTH-1:0]  respData;
  logic              ramWriteEnable;
  logic              ramReadEnable;
  logic              ramClrN;
  logic [LENGTH-1:0] ramAddr;
  logic [LENGTH-1:0] ramReadAddr;
  logic [WIDTH-1:0]  ramWriteData;
  logic              ramDataReady;
  logic [WIDTH-1:0]  ramReadData;

  modport master (
    input  reqValid, reqOp, reqAddr, reqData, ramDataReady, ramReadData,
    output reqReady, respValid, respErr, respData,
    output ramWriteEnable, ramReadEnable, ramClrN, ramAddr, ramReadAddr, ramWriteData
  );

  modport slave (
    output reqValid, reqOp, reqAddr, reqData, ramDataReady, ramReadData,
    input  reqReady, respValid, respErr, respData,
    input  ramWriteEnable, ramReadEnable, ramClrN, ramAddr, ramReadAddr, ramWriteData
  );
endinterface

// File: rtl/data_ram_master_timeout_ctr.sv
// Clear/enable cycle counter; expired_o flags the LIMIT-th enabled cycle since the last clear.
// Counter holds once expired so it never wraps while the caller is still enabled.
module data_ram_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/data_ram_master.sv
// Data RAM initiator: one request at a time, strobe for one cycle, single-cycle response; write/clear respond 1 cycle after accept, reads after dataReady.
// reqReady only in IDLE; optional read timeout with error response under DATA_RAM_TIMEOUT_EN.
module data_ram_master
  import data_ram_pkg::*;
#(
  parameter int width   = 8,
  parameter int length  = 8,
  parameter int timeout = 15
) (
  input logic               clk,
  input logic               clr,
  data_ram_master_if.master bus
);
  state_e            state_q;
  logic              wen_q;
  logic              ren_q;
  logic              clrn_q;
  logic              resp_vld_q;
  logic              resp_err_q;
  logic [length-1:0] addr_q;
  logic [width-1:0]  wdata_q;
  logic [width-1:0]  resp_dat_q;

  op_e  req_op;
  logic accept;
  logic rd_expired;

  assign req_op       = op_e'(bus.reqOp);
  assign bus.reqReady = (state_q == ST_IDLE) && !clr;
  assign accept       = bus.reqValid && bus.reqReady && (req_op != OP_NOP);

`ifdef DATA_RAM_TIMEOUT_EN
  data_ram_timeout_ctr #(
    .LIMIT (timeout)
  ) u_timeout_ctr (
    .clk       (clk),
    .rst_i     (clr),
    .clear_i   (accept && (req_op == OP_READ)),
    .en_i      (state_q == ST_READ),
    .expired_o (rd_expired)
  );
`else
  logic unused_ok;
  assign unused_ok  = (timeout > 0);
  assign rd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      clrn_q     <= 1'b1;
      resp_vld_q <= 1'b0;
      resp_err_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_dat_q <= '0;
    end else begin
      resp_vld_q <= 1'b0;
      resp_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= bus.reqAddr;
            wdata_q <= bus.reqData;
            case (req_op)
              OP_READ: begin
                ren_q   <= 1'b1;
                state_q <= ST_READ;
              end
              OP_WRITE: begin
                wen_q   <= 1'b1;
                state_q <= ST_WRITE;
              end
              OP_CLEAR: begin
                clrn_q  <= 1'b0;
                state_q <= ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
        ST_WRITE, ST_CLEAR: begin
          wen_q      <= 1'b0;
          clrn_q     <= 1'b1;
          resp_vld_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        ST_READ: begin
          // dataReady on the expiry edge still counts as a normal completion
          if (bus.ramDataReady) begin
            resp_dat_q <= bus.ramReadData;
            ren_q      <= 1'b0;
            resp_vld_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else if (rd_expired) begin
            ren_q      <= 1'b0;
            resp_vld_q <= 1'b1;
            resp_err_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.respValid      = resp_vld_q;
  assign bus.respErr        = resp_err_q;
  assign bus.respData       = resp_dat_q;
  assign bus.ramWriteEnable = wen_q;
  assign bus.ramReadEnable  = ren_q;
  assign bus.ramClrN        = clrn_q;
  assign bus.ramAddr        = addr_q;
  assign bus.ramReadAddr    = addr_q;
  assign bus.ramWriteData   = wdata_q;
endmodule

// File: tb/tb_data_ram_master.sv
// Bench for data_ram_master: RAM model on the falling edge, table of requests, hand sequences for corner cases.
module tb_data_ram_master;
  localparam logic [1:0] OPN = 2'b00, OPR = 2'b01, OPW = 2'b10, OPC = 2'b11;

  logic clk = 1'b0;
  logic clr;
  always #20 clk = ~clk;

  data_ram_master_if #(.WIDTH(8), .LENGTH(8)) bus ();

  data_ram_master #(.width(8), .length(8), .timeout(15)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // RAM model: samples strobes on the falling edge, dataReady after ram_delay wait edges
  logic [7:0] ram_mem [256];
  int ram_delay = 0;
  int wait_cnt  = 0;
  always @(negedge clk) begin
    if (!bus.ramClrN) for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
    if (bus.ramWriteEnable) ram_mem[bus.ramAddr] = bus.ramWriteData;
    if (bus.ramReadEnable) begin
      if (wait_cnt < ram_delay) begin
        wait_cnt = wait_cnt + 1;
        bus.ramDataReady <= 1'b0;
      end else begin
        bus.ramDataReady <= 1'b1;
        bus.ramReadData  <= ram_mem[bus.ramReadAddr];
      end
    end else begin
      wait_cnt = 0;
      bus.ramDataReady <= 1'b0;
    end
  end

  typedef struct packed { logic err; logic [7:0] dat; } resp_t;
  resp_t exp_q [$];

  typedef struct {
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] dat;
    int         delay;
    logic [7:0] exp_dat;
    int         exp_lat;
  } vec_t;
  vec_t vecs [10];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, then follow it to its response; hold_junk keeps a bogus write on the inputs while busy
  task automatic run_req(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] dat,
                         input int delay, input logic exp_err, input logic [7:0] exp_dat,
                         input int exp_lat, input bit hold_junk, input string tag);
    int cyc;
    bit got;
    bit busy_ok;
    logic [2:0] exp_str;
    resp_t r;
    ram_delay = delay;
    check(tag, "ready_pre", 32'(bus.reqReady), 32'd1);
    bus.reqValid = 1'b1;
    bus.reqOp    = op;
    bus.reqAddr  = addr;
    bus.reqData  = dat;
    exp_q.push_back({exp_err, exp_dat});
    tick();
    if (hold_junk) begin
      bus.reqOp   = OPW;
      bus.reqAddr = 8'h33;
      bus.reqData = 8'h99;
    end else begin
      bus.reqValid = 1'b0;
      bus.reqOp    = OPN;
    end
    case (op)
      OPR:     exp_str = 3'b011;
      OPW:     exp_str = 3'b101;
      default: exp_str = 3'b000;
    endcase
    check(tag, "strobe", 32'({bus.ramWriteEnable, bus.ramReadEnable, bus.ramClrN, bus.reqReady}),
          32'({exp_str, 1'b0}));
    check(tag, "addr_data", 32'({bus.ramAddr, bus.ramReadAddr, bus.ramWriteData}), 32'({addr, addr, dat}));
    cyc = 0;
    got = 1'b0;
    busy_ok = 1'b1;
    while (!got && cyc < 60) begin
      tick();
      cyc++;
      if (bus.respValid) got = 1'b1;
      else if (bus.reqReady || ({bus.ramWriteEnable, bus.ramReadEnable, bus.ramClrN} != exp_str)) busy_ok = 1'b0;
    end
    bus.reqValid = 1'b0;
    bus.reqOp    = OPN;
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s.resp: no respValid within 60 cycles", tag);
    end else begin
      r = exp_q.pop_front();
      check(tag, "resp", 32'({bus.respErr, bus.respData}), 32'(r));
      check(tag, "latency", 32'(cyc), 32'(exp_lat));
      check(tag, "busy", 32'(busy_ok), 32'd1);
      check(tag, "idle_after", 32'({bus.ramWriteEnable, bus.ramReadEnable, bus.ramClrN, bus.reqReady, bus.ramAddr}),
            32'({4'b0011, addr}));
      if (op == OPW) check(tag, "ram_word", 32'(ram_mem[addr]), 32'(dat));
      tick();
      check(tag, "pulse_end", 32'({bus.respValid, bus.respData}), 32'({1'b0, r.dat}));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    vecs[0] = '{OPW, 8'h05, 8'hA3, 0, 8'h00, 1};
    vecs[1] = '{OPR, 8'h05, 8'h00, 0, 8'hA3, 1};
    vecs[2] = '{OPW, 8'h10, 8'h5C, 0, 8'hA3, 1};
    vecs[3] = '{OPR, 8'h10, 8'h00, 3, 8'h5C, 4};
    vecs[4] = '{OPC, 8'h00, 8'h00, 0, 8'h5C, 1};
    vecs[5] = '{OPR, 8'h05, 8'h00, 0, 8'h00, 1};
    vecs[6] = '{OPW, 8'hFF, 8'h7E, 0, 8'h00, 1};
    vecs[7] = '{OPR, 8'hFF, 8'h00, 1, 8'h7E, 2};
    vecs[8] = '{OPW, 8'h00, 8'h11, 0, 8'h7E, 1};
    vecs[9] = '{OPR, 8'h00, 8'h00, 0, 8'h11, 1};

    clr = 1'b1;
    bus.reqValid = 1'b0;
    bus.reqOp    = OPN;
    bus.reqAddr  = 8'h00;
    bus.reqData  = 8'h00;
    repeat (3) tick();
    check("reset", "ready_in_clr", 32'(bus.reqReady), 32'd0);
    check("reset", "outputs", 32'({bus.ramWriteEnable, bus.ramReadEnable, bus.ramClrN, bus.respValid, bus.respErr, bus.respData}),
          32'({5'b00100, 8'h00}));
    check("reset", "addr_data", 32'({bus.ramAddr, bus.ramReadAddr, bus.ramWriteData}), 32'd0);
    clr = 1'b0;
    #1;
    check("reset", "ready_after", 32'(bus.reqReady), 32'd1);

    // op 00 is never accepted even with reqValid held
    bus.reqValid = 1'b1;
    bus.reqOp    = OPN;
    bus.reqAddr  = 8'h05;
    bus.reqData  = 8'h55;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({bus.ramWriteEnable, bus.ramReadEnable, bus.ramClrN, bus.reqReady, bus.respValid} != 5'b00110) ok = 1'b0;
    end
    check("nop", "ignored", 32'(ok), 32'd1);
    bus.reqValid = 1'b0;

    for (int i = 0; i < 10; i++)
      run_req(vecs[i].op, vecs[i].addr, vecs[i].dat, vecs[i].delay, 1'b0, vecs[i].exp_dat,
              vecs[i].exp_lat, 1'b0, $sformatf("vec%0d", i));

    // junk write held on the inputs while a read is outstanding must be ignored
    run_req(OPR, 8'hFF, 8'h00, 2, 1'b0, 8'h7E, 3, 1'b1, "busy_ignore");
    check("busy_ignore", "no_junk_write", 32'(ram_mem[8'h33]), 32'd0);

`ifdef DATA_RAM_TIMEOUT_EN
    run_req(OPR, 8'h10, 8'h00, 1000, 1'b1, 8'h7E, 15, 1'b0, "timeout");
`endif

    // reset while a read is stuck waiting
    ram_delay = 1000;
    bus.reqValid = 1'b1;
    bus.reqOp    = OPR;
    bus.reqAddr  = 8'h10;
    tick();
    bus.reqValid = 1'b0;
    bus.reqOp    = OPN;
    ok = 1'b1;
`ifdef DATA_RAM_TIMEOUT_EN
    repeat (5) begin
`else
    repeat (20) begin
`endif
      tick();
      if (bus.respValid || !bus.ramReadEnable || bus.reqReady) ok = 1'b0;
    end
    check("stuck_read", "waiting", 32'(ok), 32'd1);
    clr = 1'b1;
    tick();
    check("mid_reset", "strobes", 32'({bus.ramWriteEnable, bus.ramReadEnable, bus.ramClrN, bus.respValid, bus.reqReady}),
          32'(5'b00100));
    clr = 1'b0;
    #1;
    check("mid_reset", "ready", 32'(bus.reqReady), 32'd1);
    ok = 1'b1;
    repeat (3) begin
      tick();
      if (bus.respValid) ok = 1'b0;
    end
    check("mid_reset", "no_resp", 32'(ok), 32'd1);
    run_req(OPR, 8'hFF, 8'h00, 0, 1'b0, 8'h7E, 1, 1'b0, "recover");

    check("end", "queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
